dict_write_scheduler: RTL and testbench

Sequences dictionary writes for the two-lane compressor. Each cycle it takes the two input words and the 2-bit per-lane write-control (bit set = lane missed, word must enter the dictionary). It buffers up to two pushes per cycle and issues one dictionary write per cycle at a FIFO-replacement pointer. It also runs the full dictionary clear after reset or on request. It sits between the stage-2 match/control logic and the dictionary CAM write port.

---
 rtl/compress_pkg.sv | 17 +
 rtl/dict_wr_fifo.sv | 82 ++++++++
 rtl/dict_write_scheduler.sv | 144 ++++++++++++++
 tb/tb_dict_write_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/compress_pkg.sv
// Shared definitions for the compressor dictionary write path.
//   sched_state_e  : scheduler states (clear sweep / normal run)
//   *_DEF          : default sizes used by the scheduler and its FIFO
//   DICT_ADDR_W_DEF: address width of the default dictionary
package compress_pkg;

    localparam int DATA_W_DEF      = 32;
    localparam int DICT_DEPTH_DEF  = 16;
    localparam int FIFO_DEPTH_DEF  = 4;
    localparam int DICT_ADDR_W_DEF = $clog2(DICT_DEPTH_DEF);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } sched_state_e;

endpackage

// File: rtl/dict_wr_fifo.sv
// Pending dictionary-write buffer: synchronous FIFO with two ordered push
// ports (port 0 is always stored ahead of port 1) and one pop port.
// Ports:
//   clk_i, reset_i  : clock, synchronous active-high reset
//   flush_i         : discard all pending entries (synchronous)
//   push0_i/_data_i : first push of the cycle
//   push1_i/_data_i : second push of the cycle
//   pop_i           : remove the head entry
//   head_o          : current head entry
//   count_o         : number of stored entries
// The caller guarantees no push beyond capacity and no pop when empty.
module dict_wr_fifo #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              push0_i,
    input  logic [DATA_W-1:0] push0_data_i,
    input  logic              push1_i,
    input  logic [DATA_W-1:0] push1_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    // Explicit wrap so non power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_p1, wr_ptr_p2;

    assign wr_ptr_p1 = ptr_inc(wr_ptr_q);
    assign wr_ptr_p2 = ptr_inc(wr_ptr_p1);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (push0_i && push1_i) begin
            wr_ptr_d = wr_ptr_p2;
        end else if (push0_i || push1_i) begin
            wr_ptr_d = wr_ptr_p1;
        end
        rd_ptr_d = pop_i ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; pointers alone define what is valid.
    // A lone port-1 push takes the slot port 0 would have used.
    always_ff @(posedge clk_i) begin
        if (push0_i) begin
            mem_q[wr_ptr_q] <= push0_data_i;
        end
        if (push1_i) begin
            mem_q[push0_i ? wr_ptr_p1 : wr_ptr_q] <= push1_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/dict_write_scheduler.sv
// Dictionary write scheduler for the two-lane compressor. Buffers up to two
// missed-lane words per cycle and issues one dictionary write per cycle at a
// FIFO-replacement pointer; sweeps the whole dictionary clear after reset or
// on i_init.
// Ports:
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_init                : request full dictionary clear
//   i_valid, o_ready      : lane handshake
//   i_data0, i_data1      : lane words
//   i_wr_control          : bit n set = lane n word enters the dictionary
//   o_dict_we/addr/wdata/vld : registered dictionary write port
//   o_init_done           : dictionary initialised and scheduler in RUN
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_CLEAR | writing vld=0 to every entry, one per cycle; no lane accepts
// ST_RUN   | accepting lane words, draining one buffered word per cycle
module dict_write_scheduler
    import compress_pkg::*;
#(
    parameter  int DATA_W     = DATA_W_DEF,
    parameter  int DICT_DEPTH = DICT_DEPTH_DEF,
    parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int ADDR_W     = $clog2(DICT_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_init,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data0,
    input  logic [DATA_W-1:0] i_data1,
    input  logic [1:0]        i_wr_control,
    output logic              o_dict_we,
    output logic [ADDR_W-1:0] o_dict_addr,
    output logic [DATA_W-1:0] o_dict_wdata,
    output logic              o_dict_vld,
    output logic              o_init_done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    sched_state_e      state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic              dict_we_q;
    logic [ADDR_W-1:0] dict_addr_q;
    logic [DATA_W-1:0] dict_wdata_q;
    logic              dict_vld_q;
    logic              init_done_q;

    logic [DATA_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              accept;
    logic              push0, push1;
    logic              pop;

    // Two free slots are required so a two-word accept can never overflow,
    // even though a pop may free one in the same cycle.
    assign o_ready = (state_q == ST_RUN) && (fifo_count <= CNT_W'(FIFO_DEPTH - 2)) && !i_init;
    assign accept  = i_valid && o_ready;
    assign push0   = accept && i_wr_control[0];
    assign push1   = accept && i_wr_control[1];
    assign pop     = (state_q == ST_RUN) && !i_init && (fifo_count != '0);

    dict_wr_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (i_clk),
        .reset_i      (i_reset),
        .flush_i      (i_init),
        .push0_i      (push0),
        .push0_data_i (i_data0),
        .push1_i      (push1),
        .push1_data_i (i_data1),
        .pop_i        (pop),
        .head_o       (fifo_head),
        .count_o      (fifo_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            dict_we_q    <= 1'b0;
            dict_addr_q  <= '0;
            dict_wdata_q <= '0;
            dict_vld_q   <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (i_init) begin
                        // Restart the sweep from entry 0 on the next edge.
                        clr_cnt_q <= '0;
                        dict_we_q <= 1'b0;
                    end else begin
                        dict_we_q    <= 1'b1;
                        dict_addr_q  <= clr_cnt_q;
                        dict_wdata_q <= '0;
                        dict_vld_q   <= 1'b0;
                        if (clr_cnt_q == ADDR_W'(DICT_DEPTH - 1)) begin
                            clr_cnt_q   <= '0;
                            state_q     <= ST_RUN;
                            init_done_q <= 1'b1;
                        end else begin
                            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (i_init) begin
                        state_q     <= ST_CLEAR;
                        clr_cnt_q   <= '0;
                        wr_ptr_q    <= '0;
                        dict_we_q   <= 1'b0;
                        init_done_q <= 1'b0;
                    end else if (pop) begin
                        dict_we_q    <= 1'b1;
                        dict_addr_q  <= wr_ptr_q;
                        dict_wdata_q <= fifo_head;
                        dict_vld_q   <= 1'b1;
                        // DICT_DEPTH is a power of two, so natural wrap.
                        wr_ptr_q     <= wr_ptr_q + ADDR_W'(1);
                    end else begin
                        dict_we_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                end
            endcase
        end
    end

    assign o_dict_we    = dict_we_q;
    assign o_dict_addr  = dict_addr_q;
    assign o_dict_wdata = dict_wdata_q;
    assign o_dict_vld   = dict_vld_q;
    assign o_init_done  = init_done_q;

endmodule

// File: tb/tb_dict_write_scheduler.sv
module tb_dict_write_scheduler;

    logic        i_clk;
    logic        i_reset;
    logic        i_init;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data0;
    logic [31:0] i_data1;
    logic [1:0]  i_wr_control;
    logic        o_dict_we;
    logic [3:0]  o_dict_addr;
    logic [31:0] o_dict_wdata;
    logic        o_dict_vld;
    logic        o_init_done;

    int n_cmp  = 0;
    int n_fail = 0;

    dict_write_scheduler dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_init       (i_init),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data0      (i_data0),
        .i_data1      (i_data1),
        .i_wr_control (i_wr_control),
        .o_dict_we    (o_dict_we),
        .o_dict_addr  (o_dict_addr),
        .o_dict_wdata (o_dict_wdata),
        .o_dict_vld   (o_dict_vld),
        .o_init_done  (o_init_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        valid;
        logic [1:0]  ctrl;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        exp_ready;
        logic        exp_we;
        logic [3:0]  exp_addr;
        logic [31:0] exp_wdata;
        logic        exp_vld;
    } vec_t;

    vec_t vt [24];

    function automatic vec_t mk(input logic v, input logic [1:0] c,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic rdy, input logic we, input logic [3:0] ad,
                                input logic [31:0] wd, input logic vl);
        vec_t r;
        r.valid = v; r.ctrl = c; r.d0 = a; r.d1 = b;
        r.exp_ready = rdy; r.exp_we = we; r.exp_addr = ad;
        r.exp_wdata = wd; r.exp_vld = vl;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge; o_ready is sampled
    // one unit later, registered outputs 1 unit after the next rising edge.
    task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic init);
        i_valid = v; i_wr_control = c; i_data0 = a; i_data1 = b; i_init = init;
        #1;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_write(input string tag, input logic [3:0] ad, input logic [31:0] wd);
        chk({tag, " we"}, 32'(o_dict_we), 32'd1);
        chk({tag, " addr"}, 32'(o_dict_addr), 32'(ad));
        chk({tag, " wdata"}, o_dict_wdata, wd);
        chk({tag, " vld"}, 32'(o_dict_vld), 32'd1);
    endtask

    task automatic clear_sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'b11, 32'h12345678, 32'h9ABCDEF0, 1'b0);
            chk($sformatf("%s clr%0d ready", tag, i), 32'(o_ready), 32'd0);
            tick();
            chk($sformatf("%s clr%0d we", tag, i), 32'(o_dict_we), 32'd1);
            chk($sformatf("%s clr%0d addr", tag, i), 32'(o_dict_addr), 32'(i));
            chk($sformatf("%s clr%0d wdata", tag, i), o_dict_wdata, 32'd0);
            chk($sformatf("%s clr%0d vld", tag, i), 32'(o_dict_vld), 32'd0);
            chk($sformatf("%s clr%0d init_done", tag, i), 32'(o_init_done),
                (i == 15) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0]  = mk(1, 2'b11, 32'hAAAA0001, 32'hBBBB0002, 1, 0, 15, 32'h0,        0);
        vt[1]  = mk(0, 2'b00, 32'h0,        32'h0,        1, 1,  0, 32'hAAAA0001, 1);
        vt[2]  = mk(0, 2'b00, 32'h0,        32'h0,        1, 1,  1, 32'hBBBB0002, 1);
        vt[3]  = mk(0, 2'b00, 32'h0,        32'h0,        1, 0,  1, 32'hBBBB0002, 1);
        for (int i = 4; i <= 8; i++)
            vt[i] = mk(1, 2'b00, 32'h11111111, 32'h22222222, 1, 0, 1, 32'hBBBB0002, 1);
        vt[9]  = mk(1, 2'b01, 32'hC0000003, 32'hD0000004, 1, 0,  1, 32'hBBBB0002, 1);
        vt[10] = mk(0, 2'b00, 32'h0,        32'h0,        1, 1,  2, 32'hC0000003, 1);
        vt[11] = mk(1, 2'b11, 32'h10000001, 32'h10000002, 1, 0,  2, 32'hC0000003, 1);
        vt[12] = mk(1, 2'b11, 32'h20000001, 32'h20000002, 1, 1,  3, 32'h10000001, 1);
        vt[13] = mk(1, 2'b11, 32'h30000001, 32'h30000002, 0, 1,  4, 32'h10000002, 1);
        vt[14] = mk(1, 2'b11, 32'h30000001, 32'h30000002, 1, 1,  5, 32'h20000001, 1);
        vt[15] = mk(1, 2'b11, 32'h40000001, 32'h40000002, 0, 1,  6, 32'h20000002, 1);
        vt[16] = mk(1, 2'b11, 32'h40000001, 32'h40000002, 1, 1,  7, 32'h30000001, 1);
        vt[17] = mk(0, 2'b00, 32'h0,        32'h0,        0, 1,  8, 32'h30000002, 1);
        vt[18] = mk(0, 2'b00, 32'h0,        32'h0,        1, 1,  9, 32'h40000001, 1);
        vt[19] = mk(0, 2'b00, 32'h0,        32'h0,        1, 1, 10, 32'h40000002, 1);
        vt[20] = mk(0, 2'b00, 32'h0,        32'h0,        1, 0, 10, 32'h40000002, 1);
        vt[21] = mk(1, 2'b10, 32'hDEAD0000, 32'hE0000005, 1, 0, 10, 32'h40000002, 1);
        vt[22] = mk(0, 2'b11, 32'h99999999, 32'h88888888, 1, 1, 11, 32'hE0000005, 1);
        vt[23] = mk(0, 2'b00, 32'h0,        32'h0,        1, 0, 11, 32'hE0000005, 1);

        // Reset state
        i_reset = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        chk("rst we", 32'(o_dict_we), 32'd0);
        chk("rst addr", 32'(o_dict_addr), 32'd0);
        chk("rst wdata", o_dict_wdata, 32'd0);
        chk("rst vld", 32'(o_dict_vld), 32'd0);
        chk("rst init_done", 32'(o_init_done), 32'd0);
        chk("rst ready", 32'(o_ready), 32'd0);
        i_reset = 1'b0;

        clear_sweep("boot");

        // Table-driven run-mode vectors
        for (int i = 0; i < 24; i++) begin
            drive(vt[i].valid, vt[i].ctrl, vt[i].d0, vt[i].d1, 1'b0);
            chk($sformatf("vec%0d ready", i), 32'(o_ready), 32'(vt[i].exp_ready));
            tick();
            chk($sformatf("vec%0d we", i), 32'(o_dict_we), 32'(vt[i].exp_we));
            chk($sformatf("vec%0d addr", i), 32'(o_dict_addr), 32'(vt[i].exp_addr));
            chk($sformatf("vec%0d wdata", i), o_dict_wdata, vt[i].exp_wdata);
            chk($sformatf("vec%0d vld", i), 32'(o_dict_vld), 32'(vt[i].exp_vld));
            chk($sformatf("vec%0d init_done", i), 32'(o_init_done), 32'd1);
        end

        // i_init with three words pending (wr_ptr is 12 here)
        drive(1'b1, 2'b11, 32'h50000001, 32'h50000002, 1'b0);
        chk("pend0 ready", 32'(o_ready), 32'd1);
        tick();
        chk("pend0 we", 32'(o_dict_we), 32'd0);
        drive(1'b1, 2'b11, 32'h60000001, 32'h60000002, 1'b0);
        chk("pend1 ready", 32'(o_ready), 32'd1);
        tick();
        check_write("pend1", 4'd12, 32'h50000001);
        drive(1'b1, 2'b11, 32'h70000001, 32'h70000002, 1'b1);
        chk("init ready", 32'(o_ready), 32'd0);
        tick();
        chk("init we", 32'(o_dict_we), 32'd0);
        chk("init init_done", 32'(o_init_done), 32'd0);
        clear_sweep("reinit");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
            tick();
            chk($sformatf("flushed%0d we", i), 32'(o_dict_we), 32'd0);
        end

        // 18 single-word pushes: addresses 0..15 then wrap to 0, 1
        for (int j = 0; j <= 18; j++) begin
            if (j < 18) drive(1'b1, 2'b01, 32'hF0000000 + 32'(j), 32'hEEEEEEEE, 1'b0);
            else        drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
            chk($sformatf("wrap%0d ready", j), 32'(o_ready), 32'd1);
            tick();
            if (j == 0) chk("wrap0 we", 32'(o_dict_we), 32'd0);
            else check_write($sformatf("wrap%0d", j), 4'((j - 1) % 16),
                             32'hF0000000 + 32'(j - 1));
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
        tick();
        chk("wrap idle we", 32'(o_dict_we), 32'd0);

        // Reset mid-RUN has priority over a coincident i_init
        i_reset = 1'b1;
        drive(1'b1, 2'b11, 32'h77777777, 32'h66666666, 1'b1);
        tick();
        chk("midrst we", 32'(o_dict_we), 32'd0);
        chk("midrst addr", 32'(o_dict_addr), 32'd0);
        chk("midrst wdata", o_dict_wdata, 32'd0);
        chk("midrst vld", 32'(o_dict_vld), 32'd0);
        chk("midrst init_done", 32'(o_init_done), 32'd0);
        i_reset = 1'b0;
        clear_sweep("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
